// File: rtl/mad_io_int_controller.sv
// Environment-side I/O and interrupt controller for the MAD RISC core:
// input FIFO feeding In/Int, and a handshaked holding register on Out.
module mad_io_int_controller #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [WIDTH-1:0]         ext_in_data,
  input  logic                     ext_in_valid,
  output logic                     ext_in_ready,
  output logic [WIDTH-1:0]         cpu_in,
  input  logic                     cpu_in_rd,
  output logic                     cpu_int,
  input  logic                     int_en,
  input  logic [WIDTH-1:0]         cpu_out,
  input  logic                     cpu_out_wr,
  output logic [WIDTH-1:0]         ext_out_data,
  output logic                     ext_out_valid,
  input  logic                     ext_out_ready,
  output logic                     out_overrun,
  output logic [$clog2(DEPTH):0]   in_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  state_t           state;

  // Ready and head word depend only on registered FIFO state.
  assign ext_in_ready = (count != CW'(DEPTH));
  assign push         = ext_in_valid & ext_in_ready;
  assign pop          = cpu_in_rd & (count != '0);
  assign cpu_in       = (count != '0) ? mem[rd_ptr] : '0;
  assign in_count     = count;

  // FIFO storage; contents need no reset because cpu_in is gated by count.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= ext_in_data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // One interrupt per consumed word; WAIT holds until the CPU pops.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= S_IDLE;
      cpu_int <= 1'b0;
    end else begin
      cpu_int <= 1'b0;
      case (state)
        S_IDLE: begin
          if (int_en && (count != '0)) begin
            state   <= S_PULSE;
            cpu_int <= 1'b1;
          end
        end
        S_PULSE: state <= S_WAIT;
        S_WAIT:  if (pop) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output holding register; a write always wins over a concurrent handshake.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ext_out_data  <= '0;
      ext_out_valid <= 1'b0;
      out_overrun   <= 1'b0;
    end else begin
      if (cpu_out_wr) begin
        ext_out_data  <= cpu_out;
        ext_out_valid <= 1'b1;
        if (ext_out_valid && !ext_out_ready) out_overrun <= 1'b1;
      end else if (ext_out_valid && ext_out_ready) begin
        ext_out_valid <= 1'b0;
      end
    end
  end

endmodule
